// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: widths, state encoding, PC-1/PC-2/shift tables.
// Tables use DES bit numbering (bit 1 is the MSB of the vector it indexes).
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int CD_W     = 56;
  localparam int SUBKEY_W = 48;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_t;

  localparam logic [6:0] PC1_TAB [CD_W] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [5:0] PC2_TAB [SUBKEY_W] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  localparam logic [1:0] SHIFT_TAB [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [HALF_W-1:0] rot_left(input logic [HALF_W-1:0] v, input logic [1:0] n);
    logic [HALF_W-1:0] r;
    case (n)
      2'd1:    r = {v[HALF_W-2:0], v[HALF_W-1]};
      2'd2:    r = {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rot_right(input logic [HALF_W-1:0] v, input logic [1:0] n);
    logic [HALF_W-1:0] r;
    case (n)
      2'd1:    r = {v[0], v[HALF_W-1:1]};
      2'd2:    r = {v[1:0], v[HALF_W-1:2]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Set when any key byte has even parity (DES keys carry odd parity per byte).
  function automatic logic key_parity_bad(input logic [KEY_W-1:0] k);
    return ~(^k[63:56]) | ~(^k[55:48]) | ~(^k[47:40]) | ~(^k[39:32]) |
           ~(^k[31:24]) | ~(^k[23:16]) | ~(^k[15:8])  | ~(^k[7:0]);
  endfunction

endpackage

// File: rtl/des_key_pc2.sv
// Combinational DES PC-2 permutation: 56-bit C/D pair to 48-bit round subkey.
module des_key_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd_i,
  output logic [SUBKEY_W-1:0] subkey_o
);

  for (genvar g = 0; g < SUBKEY_W; g++) begin : g_pc2
    assign subkey_o[SUBKEY_W-1-g] = cd_i[CD_W - int'(PC2_TAB[g])];
  end

  // PC-2 discards C/D bits 9, 18, 22, 25, 35, 38, 43 and 54.
  logic cd_unused;
  assign cd_unused = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                       cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one registered C/D pair plus rotator emits K1..K16 or
// K16..K1 over a valid/ready handshake. Optional key parity flag: DES_KEY_PARITY_CHECK_EN.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_W-1:0]    key_in,
  input  logic                decrypt,
  output logic [SUBKEY_W-1:0] subkey_out,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [3:0]          round_idx,
  output logic                busy,
  output logic                done,
  output logic                parity_err
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 32'd1);

  state_t            state_q, state_d;
  logic [HALF_W-1:0] c_q, c_d;
  logic [HALF_W-1:0] dh_q, dh_d;
  logic [3:0]        round_q, round_d;
  logic              dec_q, dec_d;
  logic              done_q, done_d;
  logic [CD_W-1:0]   pc1_s;
  logic              start_acc_s;
  logic              xfer_s;

  for (genvar g = 0; g < CD_W; g++) begin : g_pc1
    assign pc1_s[CD_W-1-g] = key_in[KEY_W - int'(PC1_TAB[g])];
  end

  // Byte parity bits never reach PC-1.
  logic key_unused;
  assign key_unused = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                        key_in[24], key_in[16], key_in[8],  key_in[0]};

  assign start_acc_s = (state_q == IDLE) & start;
  assign xfer_s      = (state_q == RUN) & subkey_ready;

  // Next-state, rotation and round-counter logic.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    dh_d    = dh_q;
    round_d = round_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc_s) begin
          state_d = RUN;
          round_d = 4'd0;
          dec_d   = decrypt;
          // Decrypt starts from C16D16, which equals C0D0 after 28 total shifts.
          if (decrypt) begin
            c_d  = pc1_s[CD_W-1:HALF_W];
            dh_d = pc1_s[HALF_W-1:0];
          end else begin
            c_d  = rot_left(pc1_s[CD_W-1:HALF_W], SHIFT_TAB[0]);
            dh_d = rot_left(pc1_s[HALF_W-1:0], SHIFT_TAB[0]);
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (xfer_s) begin
          if (round_q == LAST_IDX) begin
            state_d = IDLE;
            round_d = 4'd0;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + 4'd1;
            if (dec_q) begin
              c_d  = rot_right(c_q, SHIFT_TAB[4'd15 - round_q]);
              dh_d = rot_right(dh_q, SHIFT_TAB[4'd15 - round_q]);
            end else begin
              c_d  = rot_left(c_q, SHIFT_TAB[round_q + 4'd1]);
              dh_d = rot_left(dh_q, SHIFT_TAB[round_q + 4'd1]);
            end
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // Schedule state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      c_q     <= '0;
      dh_q    <= '0;
      round_q <= 4'd0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      dh_q    <= dh_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  des_key_pc2 u_pc2 (
    .cd_i     ({c_q, dh_q}),
    .subkey_o (subkey_out)
  );

  assign subkey_valid = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign round_idx    = round_q;
  assign done         = done_q;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic parity_q, parity_d;

  // Parity flag is captured with each accepted start and held until the next one.
  always_comb begin
    parity_d = parity_q;
    if (start_acc_s) begin
      parity_d = key_parity_bad(key_in);
    end else begin
      parity_d = parity_q;
    end
  end

  // Parity flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Iterative DES key scheduler. Directly upstream of the DES round datapath (des core): turns one 64-bit key into the 16 48-bit round subkeys.
- Emits one subkey per accepted handshake.
- Emits them in encrypt order (K1..K16) or decrypt order (K16..K1).
- Replaces per-round combinational key logic with one registered C/D pair and a rotator.

Parameters:
- NUM_ROUNDS, 16, number of subkeys per schedule (fixed for DES; bench checks only 16).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new schedule; accepted only when busy=0.
- key_in  input  64  DES key; key_in[63] = DES bit 1. Parity bits ignored by the permutation.
- decrypt  input  1  1 = decrypt order (K16 first); 0 = encrypt order. Sampled with start.
- subkey_out  output  48  current round subkey; subkey_out[47] = PC-2 bit 1.
- subkey_valid  output  1  subkey_out holds a valid subkey.
- subkey_ready  input  1  consumer accepts subkey_out this cycle.
- round_idx  output  4  0..15: position of the current subkey in emission order.
- busy  output  1  schedule in progress.
- done  output  1  one-cycle pulse after the 16th subkey is accepted.
- parity_err  output  1  key parity flag (see Optional Feature).

Behaviour:
- Reset (async, any time, including mid-schedule): state=IDLE; C,D=0; subkey_out=0; subkey_valid=0; round_idx=0; busy=0; done=0; parity_err=0. Any partial schedule is abandoned.
- State machine has two states, IDLE and RUN.
- IDLE:
  - start=1 → latch mode; C,D = PC-1(key_in) (28+28 bits).
  - Encrypt: C,D are also left-rotated by shift[1]=1 in the same cycle.
  - Decrypt: no rotation (C16D16 = C0D0).
  - Next state RUN. busy=1 and subkey_valid=1 from the next cycle.
- Latency: start accepted at cycle t → first subkey valid at t+1.
- Subkey output: subkey_out = PC-2(C,D), registered from the C/D registers (combinational PC-2 of registered state), so it is stable while valid and not ready.
- RUN, handshake transfer = subkey_valid & subkey_ready:
  - No transfer: C, D, round_idx hold.
  - Transfer with round_idx<15: round_idx+1, then rotate C,D.
  - Encrypt rotation: left rotate by shift[round_idx+2].
  - Decrypt rotation: right rotate by shift[16-round_idx].
  - Rotations are modulo 28, each half independent.
- Shift table (rounds 1..16): 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Transfer at round_idx=15: state→IDLE; subkey_valid=0; busy=0; round_idx=0; done=1 for exactly one cycle.
- start while busy=1: ignored, with no effect on the current schedule.
- start in the cycle done=1: legal and accepted (busy is already 0). Back-to-back schedules have one idle cycle between the last and the first subkey.
- subkey_ready while subkey_valid=0: ignored.
- key_in and decrypt are don't-care after start is accepted.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN.
- Defined:
  - When start is accepted, each key byte is checked for odd parity.
  - parity_err is registered =1 if any byte has even parity, and holds until the next accepted start or reset.
  - The schedule still runs (flag only, no abort).
- Undefined: parity_err is tied 0, no parity logic is synthesised, and the port is still present.

Decomposition:
- Package des_pkg:
  - PC1 table (56 entries), PC2 table (48 entries), SHIFT table (16 entries).
  - Localparams for state encoding (IDLE, RUN).
  - Widths KEY_W=64, HALF_W=28, SUBKEY_W=48.
- Sub-module des_key_pc2: combinational 56→48 PC-2 permutation, reusable by the round datapath's bench model.
- PC-1 and the rotator stay inline.

Test Plan:
- Encrypt vector: key 133457799BBCDFF1, decrypt=0, subkey_ready=1 continuously:
  - K1=1B02EFFC7072 one cycle after start; 16 consecutive valid cycles; last = CB3D8B0E17F5.
  - done pulse at the cycle after the 16th transfer.
- Decrypt order: same key, decrypt=1:
  - first subkey CB3D8B0E17F5, last 1B02EFFC7072.
  - Full sequence equals the encrypt sequence reversed.
- Backpressure: random subkey_ready (≈50%):
  - subkey_out and round_idx stable while valid & !ready.
  - Sequence identical to the first scenario.
  - start pulses issued while busy are ignored.
- Reset mid-operation: assert reset at round_idx=7 → all outputs 0 immediately (async). A new start after release yields a correct K1.
- Boundaries:
  - Key 0000000000000000 → all 16 subkeys 000000000000.
  - Start asserted in the done cycle with key 10316E028C8F3B4A → accepted; schedule completes with 16 transfers.
- Parity (macro defined):
  - Key 133457799BBCDFF1 → parity_err=0.
  - Key 0000000000000000 → parity_err=1.
  - Macro undefined → parity_err always 0.
